// File: rtl/hilo_mul_seq.sv
// Iterative unsigned shift-add multiplier owning the HI/LO pair; executes multu/maddu
// over WIDTH+1 cycles and stalls the front end while a product is in flight.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for a multu/maddu; HI/LO reads served directly
//   S_BUSY  | WIDTH shift-add iterations over the partial product
//   S_WRITE | commit product (multu) or accumulate into HI:LO (maddu)
module hilo_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [1:0]       mul,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               maddu_q, maddu_d;
    logic [2*WIDTH:0]   p_q, p_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               mul_req;
    logic               accept;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   p_step;
    logic [2*WIDTH-1:0] acc_sum;

    assign mul_req = issue_valid & ((mul == 2'b01) | (mul == 2'b10));
    assign accept  = mul_req & (state_q == S_IDLE) & ~flush;

    // Upper half is one bit wider so the add carry survives the following shift.
    always_comb begin
        upper_sum = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        p_step    = {upper_sum, p_q[WIDTH-1:0]} >> 1;
        acc_sum   = {hi_q, lo_q} + p_q[2*WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        maddu_d = maddu_q;
        p_d     = p_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = rs_val;
                    maddu_d = (mul == 2'b10);
                    p_d     = {{(WIDTH+1){1'b0}}, rt_val};
                    count_d = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    p_d     = p_step;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (maddu_q) begin
                        {hi_d, lo_d} = acc_sum;
                    end else begin
                        {hi_d, lo_d} = p_q[2*WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            maddu_q <= 1'b0;
            p_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            maddu_q <= maddu_d;
            p_q     <= p_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A reserved mul code alone never holds the pipeline; only real multiplies or reads do.
    assign stall = ~rst & issue_valid & (mul_req | (sel != 2'b00))
                   & (state_q != S_IDLE) & ~flush;

    always_comb begin
        hilo_rdata = '0;
        if (!rst) begin
            case (sel)
                2'b01:   hilo_rdata = hi_q;
                2'b10:   hilo_rdata = lo_q;
                default: hilo_rdata = '0;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
